// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file slice.
package mips_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/mips_regfile_bypass.sv
// Per-read-port write-first select: zero, port B, port A, then storage.
module mips_regfile_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] wr_addr_a_i,
    input  logic [DATA_W-1:0] wr_data_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] wr_addr_b_i,
    input  logic [DATA_W-1:0] wr_data_b_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic is_zero;
    logic hit_a;
    logic hit_b;

    assign is_zero = ZERO_REG && (rd_addr_i == '0);
    assign hit_a   = we_a_i && (wr_addr_a_i == rd_addr_i);
    assign hit_b   = we_b_i && (wr_addr_b_i == rd_addr_i);

    always_comb begin
        rd_data_o = ram_data_i;
        if (is_zero) begin
            rd_data_o = '0;
        end else if (hit_b) begin
            rd_data_o = wr_data_b_i;
        end else if (hit_a) begin
            rd_data_o = wr_data_a_i;
        end
    end

endmodule

// File: rtl/mips_regfile_2w2r.sv
// Two-write / two-read register file with clear sweep, bypass and
// same-address write arbitration (port B wins).
module mips_regfile_2w2r
    import mips_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              conflict,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic [DATA_W-1:0] wr_data_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              conflict_q, conflict_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              run;
    logic              we_a;
    logic              we_b;
    logic [DATA_W-1:0] byp_a;
    logic [DATA_W-1:0] byp_b;

    assign run  = (state_q == ST_RUN);
    assign we_a = run && wr_en_a &&
                  !(ZERO_REG && (wr_addr_a == '0));
    assign we_b = run && wr_en_b &&
                  !(ZERO_REG && (wr_addr_b == '0));

    mips_regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_byp_a (
        .rd_addr_i   (rd_addr_a),
        .we_a_i      (we_a),
        .wr_addr_a_i (wr_addr_a),
        .wr_data_a_i (wr_data_a),
        .we_b_i      (we_b),
        .wr_addr_b_i (wr_addr_b),
        .wr_data_b_i (wr_data_b),
        .ram_data_i  (ram_q[rd_addr_a]),
        .rd_data_o   (byp_a)
    );

    mips_regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_byp_b (
        .rd_addr_i   (rd_addr_b),
        .we_a_i      (we_a),
        .wr_addr_a_i (wr_addr_a),
        .wr_data_a_i (wr_data_a),
        .we_b_i      (we_b),
        .wr_addr_b_i (wr_addr_b),
        .wr_data_b_i (wr_data_b),
        .ram_data_i  (ram_q[rd_addr_b]),
        .rd_data_o   (byp_b)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        conflict_d = 1'b0;
        rd_a_d     = '0;
        rd_b_d     = '0;
        unique case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d    = 1'b1;
                conflict_d = we_a && we_b &&
                             (wr_addr_a == wr_addr_b);
                rd_a_d     = byp_a;
                rd_b_d     = byp_b;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
        end
    end

    // Storage has no reset; B is written last so it wins a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                ram_q[idx_q] <= '0;
            end else begin
                if (we_a) begin
                    ram_q[wr_addr_a] <= wr_data_a;
                end
                if (we_b) begin
                    ram_q[wr_addr_b] <= wr_data_b;
                end
            end
        end
    end

    assign ready     = ready_q;
    assign conflict  = conflict_q;
    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;

endmodule

// File: doc/mips_regfile_2w2r.md
# mips_regfile_2w2r

Parametrised two-write / two-read register file for the MIPS datapath, succeeding the fixed 32x32 dual-port register RAM. It adds a configurable width and depth, an optional hardwired zero register, write-first bypass across both write ports, same-address write arbitration with a conflict flag, and a post-reset clear sweep with a ready handshake. It sits between decode (read addresses) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes
- CLEAR_ON_RESET, 1, 1: zero every register after reset; 0: contents left untouched

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  register file usable; writes honoured only while high
- conflict  out  1  one-cycle pulse: both ports wrote the same address in the previous cycle
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  registered read data
- wr_en_a, wr_en_b  in  1  write enables
- wr_addr_a, wr_addr_b  in  ADDR_W  write addresses
- wr_data_a, wr_data_b  in  DATA_W  write data

## Operation
- States: CLEAR, RUN. While rst is high at an edge: state <= CLEAR (CLEAR_ON_RESET=1) or RUN (=0); sweep index <= 0; ready, conflict, rd_data_a and rd_data_b <= 0.
- CLEAR: each edge with rst low writes 0 to ram[idx] and increments idx. The edge that clears idx = DEPTH-1 sets state <= RUN and ready <= 1. During CLEAR all write ports are ignored and both read ports return 0.
- RUN with CLEAR_ON_RESET=0: ready <= 1 on the first edge with rst low.
- Writes (RUN only): a port writes when its wr_en is high, unless ZERO_REG=1 and its address is 0.
- Same-address write from both ports: port B wins, and conflict is pulsed on the next edge. No pulse when the shared address is a suppressed register 0.
- Reads (RUN): write-first bypass, priority order:
  - 0 if ZERO_REG=1 and the address is 0;
  - wr_data_b on an effective B write to the same address;
  - wr_data_a on an effective A write to the same address;
  - otherwise ram[addr].
- Both read ports are independent and may name the same address.
- rst asserted mid-sweep or mid-operation: the sweep restarts at idx 0. Contents not yet cleared keep their old values until swept.

## Timing
- Read latency: 1 cycle. The address presented before edge N yields data after edge N.
- Write latency: 1 cycle. A write before edge N is visible to a non-bypassed read issued in cycle N+1 and later. A read issued in the same cycle as the write returns the new data via bypass.
- Clear sweep: ready rises at the DEPTH-th edge with rst low (32 edges at defaults).
- conflict: high for exactly one cycle per conflicting write cycle. It stays high across back-to-back conflicting cycles.

## Structure
- Shared package mips_pkg: state enum (ST_CLEAR, ST_RUN), default DATA_W/ADDR_W constants.
- Sub-module mips_regfile_bypass: combinational per-read-port select (zero/B/A/ram), instantiated twice.
- Top holds the storage array, the sweep FSM, write arbitration and the output registers.

## Test plan
- Reset sweep (defaults): preload the array with nonzero values, pulse rst for 1 cycle. Expect ready low for 31 edges, high at the 32nd; then reads of regs 1..31 all return 0. A write attempted during the sweep is lost.
- Basic write/read: write A reg 5 = 0xDEADBEEF, then read A and B at reg 5. Expect 0xDEADBEEF one cycle after the read address.
- Bypass: in the same cycle, write A reg 7 = 0x11 and read rd_addr_b = 7. Expect rd_data_b = 0x11 next cycle.
- Conflict: write A reg 9 = 0xAAAA and B reg 9 = 0xBBBB in the same cycle. Expect conflict = 1 for one cycle and a later read of reg 9 = 0xBBBB.
- Zero register: write A reg 0 = 0xFFFF with ZERO_REG=1. Expect a read of reg 0 = 0 and no conflict. With ZERO_REG=0, expect the read to return 0xFFFF.
- Reset mid-sweep: assert rst at sweep idx 10. Expect ready to stay low until 32 edges after release.
